// File: rtl/memory_arbiter_pkg.sv
// Shared encodings for the memory arbiter: memory op, FSM states, owner, alignment mask.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package memory_arbiter_pkg;

  localparam logic        MEM_READ        = 1'b0;
  localparam logic        MEM_WRITE       = 1'b1;
  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;
  localparam logic [3:0]  FULL_WORD_MASK  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_LSU   = 1'b1
  } owner_t;

endpackage

// File: rtl/arbiter_priority.sv
// Grant policy: LSU beats fetch unless fetch has been passed over STARVE_LIMIT times in a row.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is taken.
module arbiter_priority
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             fetch_req,
  input  logic             lsu_req,
  input  logic [CNT_W-1:0] starve_cnt,
  output logic             grant,
  output owner_t           winner
);

  logic starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Pick the winner among pending requesters
  always_comb begin
    grant  = fetch_req | lsu_req;
    winner = OWN_FETCH;
    if (lsu_req && !(fetch_req && starved)) begin
      winner = OWN_LSU;
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Serialises fetch and LSU requests onto one memory port with word-aligned addresses and a watchdog.
// Latency: request edge N -> mem_enable from N+1; mem_done at edge M -> done pulse in cycle M+1.
// Backpressure: requests are held until their done pulse; one transaction in flight at a time.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_address,
  output logic [31:0] fetch_data,
  output logic        fetch_done,
  input  logic        lsu_req,
  input  logic        lsu_write,
  input  logic [3:0]  lsu_frame_mask,
  input  logic [31:0] lsu_address,
  input  logic [31:0] lsu_store_data,
  output logic [31:0] lsu_load_data,
  output logic        lsu_done,
  output logic        error,
  output logic        mem_enable,
  output logic        mem_state,
  output logic [3:0]  mem_frame_mask,
  output logic [31:0] mem_address,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_done
);

  localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state;
  state_t          state_nxt;
  owner_t          owner;
  owner_t          winner;
  logic            grant;
  logic            abort;
  logic            wd_expire;
  logic [SC_W-1:0] starve_cnt;
  logic [WD_W-1:0] wd_cnt;

  arbiter_priority #(
    .STARVE_LIMIT(STARVE_LIMIT),
    .CNT_W       (SC_W)
  ) u_prio (
    .fetch_req (fetch_req),
    .lsu_req   (lsu_req),
    .starve_cnt(starve_cnt),
    .grant     (grant),
    .winner    (winner)
  );

  // wd_cnt holds the 1-based index of the current BUSY cycle
  assign wd_expire = (wd_cnt == WD_W'(TIMEOUT));

  // State register
  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic and per-state strobes; mem_done wins over the watchdog
  always_comb begin
    state_nxt  = state;
    mem_enable = 1'b0;
    fetch_done = 1'b0;
    lsu_done   = 1'b0;
    error      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        mem_enable = 1'b1;
        if (mem_done || wd_expire) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        fetch_done = (owner == OWN_FETCH);
        lsu_done   = (owner == OWN_LSU);
        error      = abort;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Transaction latch, starve counter, watchdog and response data registers
  always_ff @(posedge CLK) begin
    if (reset) begin
      owner          <= OWN_FETCH;
      abort          <= 1'b0;
      starve_cnt     <= '0;
      wd_cnt         <= '0;
      mem_state      <= MEM_READ;
      mem_frame_mask <= '0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      fetch_data     <= '0;
      lsu_load_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner  <= winner;
            abort  <= 1'b0;
            wd_cnt <= WD_W'(1);
            if (winner == OWN_LSU) begin
              mem_address    <= lsu_address & WORD_ALIGN_MASK;
              mem_state      <= lsu_write ? MEM_WRITE : MEM_READ;
              mem_frame_mask <= lsu_frame_mask;
              mem_wdata      <= lsu_store_data;
              // Only LSU grants that bypass a waiting fetch count toward starvation
              if (!fetch_req) begin
                starve_cnt <= '0;
              end else if (starve_cnt != SC_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + SC_W'(1);
              end
            end else begin
              mem_address    <= fetch_address & WORD_ALIGN_MASK;
              mem_state      <= MEM_READ;
              mem_frame_mask <= FULL_WORD_MASK;
              mem_wdata      <= '0;
              starve_cnt     <= '0;
            end
          end
        end
        ST_BUSY: begin
          if (mem_done) begin
            if (owner == OWN_FETCH)        fetch_data    <= mem_rdata;
            else if (mem_state == MEM_READ) lsu_load_data <= mem_rdata;
          end else if (wd_expire) begin
            abort <= 1'b1;
            if (owner == OWN_FETCH) fetch_data    <= '0;
            else                    lsu_load_data <= '0;
          end else begin
            wd_cnt <= wd_cnt + WD_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
